// File: rtl/doraemon_pkg.sv
// Shared types and constants for the doraemon transmitter.
// Holds the record and weight structs, the FSM state enum and the LFSR
// seed/tap constants used when the pacing gap generator is built in.
package doraemon_pkg;

  typedef struct packed {
    logic [4:0] id;
    logic [7:0] size;
    logic [7:0] iq;
    logic [7:0] eq;
  } rec_t;

  typedef struct packed {
    logic [2:0] size_w;
    logic [2:0] iq_w;
    logic [2:0] eq_w;
  } weights_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Seed and taps (8,6,5,4 -> bits 7,5,4,3) of the 8-bit Fibonacci LFSR.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Shift left and feed the XOR of the tapped bits into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/doraemon_tx_fifo.sv
// tx_fifo: synchronous DEPTH-entry skid FIFO for doraemon records.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy counter. A push into a full FIFO is
// refused even if a pop happens in the same cycle, and a record pushed
// into an empty FIFO only becomes visible at the head on the next cycle.
module tx_fifo
  import doraemon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rec_t push_data,
  input  logic pop,
  output rec_t pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  rec_t        r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_push_ok;
  logic        w_pop_ok;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;
  assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the FIFO by realigning both pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/doraemon_tx.sv
// doraemon_tx: streams exactly TOTAL records per frame from a skid FIFO
// onto the scorer input bus, honouring the scorer's registered ready.
// Optional macro DORAEMON_TX_GAP_EN adds an LFSR that inserts
// pseudo-random idle cycles on the bus; without it gap_ok is constant 1.
module doraemon_tx
  import doraemon_pkg::*;
#(
  parameter int TOTAL = 6000,
  parameter int DEPTH = 4,
  parameter int CW    = 13
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    cfg_size_w,
  input  logic [2:0]    cfg_iq_w,
  input  logic [2:0]    cfg_eq_w,
  input  logic          rec_valid,
  output logic          rec_ready,
  input  logic [4:0]    rec_id,
  input  logic [7:0]    rec_size,
  input  logic [7:0]    rec_iq,
  input  logic [7:0]    rec_eq,
  input  logic          ready,
  output logic          in_valid,
  output logic [4:0]    doraemon_id,
  output logic [7:0]    size,
  output logic [7:0]    iq_score,
  output logic [7:0]    eq_score,
  output logic [2:0]    size_weight,
  output logic [2:0]    iq_weight,
  output logic [2:0]    eq_weight,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] sent_cnt
);

  localparam logic [CW:0]   TOTAL_W = (CW + 1)'(TOTAL);
  localparam logic [CW-1:0] CNT_ONE = {{(CW - 1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_state_nxt;
  weights_t      r_wts;
  rec_t          r_bus;
  rec_t          w_head;
  rec_t          w_in_rec;
  logic          r_in_valid;
  logic [CW-1:0] r_sent_cnt;
  logic          w_full;
  logic          w_empty;
  logic          w_start_acc;
  logic          w_below;
  logic          w_gap_ok;
  logic          w_pop;

  assign w_in_rec    = {rec_id, rec_size, rec_iq, rec_eq};
  assign w_start_acc = (r_state == ST_IDLE) & start;

  // The record already on the bus counts as sent when deciding whether another may follow.
  assign w_below = ({1'b0, r_sent_cnt} + {{CW{1'b0}}, r_in_valid}) < TOTAL_W;
  assign w_pop   = (r_state == ST_SEND) & ready & ~w_empty & w_below & w_gap_ok;

  tx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk1),
    .rst      (rst),
    .push     (rec_valid),
    .push_data(w_in_rec),
    .pop      (w_pop),
    .pop_data (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign rec_ready = ~w_full;

`ifdef DORAEMON_TX_GAP_EN
  logic [7:0] r_lfsr;

  // Pacing LFSR: reseeded for each frame and stepped once per SEND cycle.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_start_acc) begin
      r_lfsr <= LFSR_SEED;
    end else if (r_state == ST_SEND) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_gap_ok = ~r_lfsr[0];
`else
  assign w_gap_ok = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic plus busy/done, which follow directly from the state.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        busy = 1'b1;
        if (({1'b0, r_sent_cnt} == TOTAL_W) && !r_in_valid) w_state_nxt = ST_FIN;
      end
      ST_FIN: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Weights are captured only when a start is accepted and held across the frame.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst)              r_wts <= '0;
    else if (w_start_acc) r_wts <= '{size_w: cfg_size_w, iq_w: cfg_iq_w, eq_w: cfg_eq_w};
  end

  // Output bus register: a pop places the head record on the bus, otherwise the fields go to zero.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_in_valid <= 1'b0;
      r_bus      <= '0;
    end else begin
      r_in_valid <= w_pop;
      r_bus      <= w_pop ? w_head : '0;
    end
  end

  // Sent counter: cleared by an accepted start, counts every cycle the bus is valid.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst)              r_sent_cnt <= '0;
    else if (w_start_acc) r_sent_cnt <= '0;
    else if (r_in_valid)  r_sent_cnt <= r_sent_cnt + CNT_ONE;
  end

  assign in_valid    = r_in_valid;
  assign doraemon_id = r_bus.id;
  assign size        = r_bus.size;
  assign iq_score    = r_bus.iq;
  assign eq_score    = r_bus.eq;
  assign size_weight = r_wts.size_w;
  assign iq_weight   = r_wts.iq_w;
  assign eq_weight   = r_wts.eq_w;
  assign sent_cnt    = r_sent_cnt;

endmodule
